esc_bank: RTL

- Parametrised multi-channel ESC PWM driver; successor to the fixed four-channel ESC wrapper.
- Generates one shared-frame PWM output per motor from a packed speed bus.
- Adds a post-reset arming sequence, per-channel slew-rate limiting and glitch-free frame-boundary updates.
- Sits between the flight controller's speed outputs and the motor ESC pins.

---
 rtl/esc_bank.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/esc_bank.sv
// esc_bank: parametrised multi-channel ESC PWM driver with post-reset arming, per-channel slew limiting and frame-aligned pulse updates.
// Latency: wrt -> target in 1 clk; the applied pulse width changes only on frame wrap, by at most RAMP_STEP speed LSBs per frame.
// Backpressure: none; wrt is a strobe accepted every cycle and ignored while motors_off is high.
// Optional feature: define ESC_CLAMP_EN to saturate captured targets to MAX_SPD.
// Ports: clk, rst_n (async active-low) | wrt strobe, motors_off level, spd packed speeds (channel i = spd[i*SPD_W +: SPD_W])
//        | pwm per-channel outputs, frame_start one-cycle wrap pulse, armed high once arming is complete.
module esc_bank #(
   parameter int NUM_CH     = 4,
   parameter int SPD_W      = 11,
   parameter int PERIOD     = 4096,
   parameter int BASE       = 100,
   parameter int MULT       = 1,
   parameter int RAMP_STEP  = 256,
   parameter int ARM_FRAMES = 2,
   parameter int MAX_SPD    = 1800
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wrt,
   input  logic                    motors_off,
   input  logic [NUM_CH*SPD_W-1:0] spd,
   output logic [NUM_CH-1:0]       pwm,
   output logic                    frame_start,
   output logic                    armed
);

   localparam int PER_W  = $clog2(PERIOD);
   localparam int ARM_W  = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
   // A step wider than the speed range behaves like a full-range step.
   localparam int STEP_I = (RAMP_STEP < 2**SPD_W) ? RAMP_STEP : (2**SPD_W - 1);

   localparam logic signed [SPD_W:0] STEP_S  = (SPD_W+1)'(STEP_I);
   localparam logic signed [SPD_W:0] NSTEP_S = (SPD_W+1)'(-STEP_I);
   localparam logic [SPD_W-1:0]      STEP_U  = SPD_W'(STEP_I);
   localparam logic [PER_W-1:0]      BASE_C  = PER_W'(BASE);
   localparam logic [PER_W-1:0]      MULT_C  = PER_W'(MULT);
   localparam logic [PER_W-1:0]      LAST_C  = PER_W'(PERIOD - 1);

   if (BASE + (2**SPD_W - 1) * MULT >= PERIOD) begin : g_chk_period
      $error("esc_bank: BASE + (2^SPD_W-1)*MULT must be below PERIOD");
   end
   if (ARM_FRAMES < 1) begin : g_chk_arm
      $error("esc_bank: ARM_FRAMES must be at least 1");
   end
   if (MAX_SPD < 0 || MAX_SPD >= 2**SPD_W) begin : g_chk_max
      $error("esc_bank: MAX_SPD must fit in SPD_W bits");
   end

`ifdef ESC_CLAMP_EN
   localparam logic [SPD_W-1:0] MAX_C = SPD_W'(MAX_SPD);
`endif

   function automatic logic [SPD_W-1:0] cap_val(input logic [SPD_W-1:0] v);
`ifdef ESC_CLAMP_EN
      cap_val = (v > MAX_C) ? MAX_C : v;
`else
      cap_val = v;
`endif
   endfunction

   typedef enum logic {
      ST_ARM = 1'b0,
      ST_RUN = 1'b1
   } state_e;

   state_e                   state_q, state_d;
   logic [ARM_W-1:0]         arm_cnt_q, arm_cnt_d;
   logic                     armed_q, armed_d;
   logic [PER_W-1:0]         cnt_q, cnt_d;
   logic                     frame_start_q, frame_start_d;
   logic                     live_q, live_d;
   logic [NUM_CH-1:0]        pwm_q, pwm_d;
   logic [SPD_W-1:0]         tgt_q [NUM_CH];
   logic [SPD_W-1:0]         tgt_d [NUM_CH];
   logic [SPD_W-1:0]         cur_q [NUM_CH];
   logic [SPD_W-1:0]         cur_d [NUM_CH];
   logic [PER_W-1:0]         cmp_q [NUM_CH];
   logic [PER_W-1:0]         cmp_d [NUM_CH];
   logic signed [SPD_W:0]    diff  [NUM_CH];
   logic                     bnd;

   // Frame counter, arming FSM.
   always_comb begin
      bnd           = (cnt_q == LAST_C);
      cnt_d         = bnd ? '0 : cnt_q + 1'b1;
      frame_start_d = bnd;
      // pwm stays low until the first wrap so the partial frame after reset
      // cannot produce a short pulse.
      live_d        = live_q | bnd;
      state_d       = state_q;
      arm_cnt_d     = arm_cnt_q;
      armed_d       = armed_q;
      case (state_q)
         ST_ARM: begin
            if (bnd) begin
               arm_cnt_d = arm_cnt_q + 1'b1;
               if (arm_cnt_q == ARM_W'(ARM_FRAMES - 1)) begin
                  state_d = ST_RUN;
                  armed_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_ARM;
         end
      endcase
   end

   // Per-channel target capture, slew step and compare reload.
   always_comb begin
      pwm_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         tgt_d[i] = tgt_q[i];
         cur_d[i] = cur_q[i];
         cmp_d[i] = cmp_q[i];
         diff[i]  = $signed({1'b0, tgt_q[i]}) - $signed({1'b0, cur_q[i]});

         if (wrt) begin
            tgt_d[i] = cap_val(spd[i*SPD_W +: SPD_W]);
         end

         // The step reads tgt_q, so a wrt landing on the boundary edge is
         // only seen from the following frame. In ARM cur is never moved.
         if (bnd && state_q == ST_RUN) begin
            if (diff[i] > STEP_S) begin
               cur_d[i] = cur_q[i] + STEP_U;
            end else if (diff[i] < NSTEP_S) begin
               cur_d[i] = cur_q[i] - STEP_U;
            end else begin
               cur_d[i] = tgt_q[i];
            end
         end

         if (motors_off) begin
            tgt_d[i] = '0;
            cur_d[i] = '0;
         end

         // cmp only moves at the wrap, so the running pulse always finishes
         // with the width it started with.
         if (bnd) begin
            cmp_d[i] = BASE_C + PER_W'(cur_d[i]) * MULT_C;
         end

         pwm_d[i] = live_d && (cnt_d < cmp_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         frame_start_q <= 1'b0;
         live_q        <= 1'b0;
         pwm_q         <= '0;
         state_q       <= ST_ARM;
         arm_cnt_q     <= '0;
         armed_q       <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            tgt_q[i] <= '0;
            cur_q[i] <= '0;
            cmp_q[i] <= BASE_C;
         end
      end else begin
         cnt_q         <= cnt_d;
         frame_start_q <= frame_start_d;
         live_q        <= live_d;
         pwm_q         <= pwm_d;
         state_q       <= state_d;
         arm_cnt_q     <= arm_cnt_d;
         armed_q       <= armed_d;
         for (int i = 0; i < NUM_CH; i++) begin
            tgt_q[i] <= tgt_d[i];
            cur_q[i] <= cur_d[i];
            cmp_q[i] <= cmp_d[i];
         end
      end
   end

   assign pwm         = pwm_q;
   assign frame_start = frame_start_q;
   assign armed       = armed_q;

endmodule
